// File: rtl/dlx_decode_stage.sv
// dlx_decode_stage: handshaked DLX decode stage with output register, load-use interlock,
// flush and illegal-opcode detection.
module dlx_decode_stage #(
    parameter int         XLEN      = 32,
    parameter bit         HAZARD_EN = 1'b1,
    parameter logic [4:0] LINK_REG  = 5'd31
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            d_write_enable,
    output logic            d_load_enable,
    output logic            rf_write_enable,
    output logic            Iv_alu,
    output logic            Pc_alu,
    output logic [1:0]      Pc_cmd,
    output logic [3:0]      I,
    output logic [4:0]      Rs1,
    output logic [4:0]      Rs2,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] Iv,
    output logic            illegal
);
    typedef struct packed {
        logic            dwe;
        logic            dle;
        logic            rfwe;
        logic            iv_alu;
        logic            pc_alu;
        logic [1:0]      pc_cmd;
        logic [3:0]      alu;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] iv;
        logic            illegal;
    } ctl_t;

    ctl_t            ctl_d, ctl_q;
    logic            valid_d, valid_q, hazard, accept, wr, ok;
    logic [XLEN-1:0] pc_q, sext16, zext16, sext26, lhi;
    logic [5:0]      op, fn;

    assign op     = in_instr[31:26];
    assign fn     = in_instr[5:0];
    assign sext16 = XLEN'($signed(in_instr[15:0]));
    assign zext16 = XLEN'(in_instr[15:0]);
    assign sext26 = XLEN'($signed(in_instr[25:0]));
    assign lhi    = XLEN'({in_instr[15:0], 16'h0000});

    // Defaults describe a plain I-type op; each opcode overrides what differs.
    always_comb begin
        ctl_d        = '0;
        wr           = 1'b0;
        ok           = 1'b1;
        ctl_d.rs1    = in_instr[25:21];
        ctl_d.rd     = in_instr[20:16];
        ctl_d.iv     = sext16;
        ctl_d.iv_alu = 1'b1;
        case (op)
            6'h00: begin
                ctl_d.rs2    = in_instr[20:16];
                ctl_d.rd     = in_instr[15:11];
                ctl_d.iv     = '0;
                ctl_d.iv_alu = 1'b0;
                wr           = 1'b1;
                case (fn)
                    6'h20: ctl_d.alu = 4'd0;
                    6'h22: ctl_d.alu = 4'd1;
                    6'h24: ctl_d.alu = 4'd2;
                    6'h25: ctl_d.alu = 4'd3;
                    6'h26: ctl_d.alu = 4'd4;
                    6'h04: ctl_d.alu = 4'd5;
                    6'h06: ctl_d.alu = 4'd6;
                    6'h07: ctl_d.alu = 4'd7;
                    6'h2A: ctl_d.alu = 4'd8;
                    default: ok = 1'b0;
                endcase
            end
            6'h08: wr = 1'b1;
            6'h0C, 6'h0D, 6'h0E: begin
                ctl_d.alu = (op == 6'h0C) ? 4'd2 : (op == 6'h0D) ? 4'd3 : 4'd4;
                ctl_d.iv  = zext16;
                wr        = 1'b1;
            end
            6'h0F: begin
                ctl_d.alu = 4'd9;
                ctl_d.iv  = lhi;
                ctl_d.rs1 = '0;
                wr        = 1'b1;
            end
            6'h23: begin
                ctl_d.dle = 1'b1;
                wr        = 1'b1;
            end
            6'h2B: begin
                ctl_d.dwe = 1'b1;
                ctl_d.rs2 = in_instr[20:16];
                ctl_d.rd  = '0;
            end
            6'h04, 6'h05: begin
                ctl_d.pc_cmd = (op == 6'h04) ? 2'd1 : 2'd2;
                ctl_d.rd     = '0;
            end
            6'h12, 6'h13: begin
                ctl_d.pc_cmd = 2'd3;
                ctl_d.pc_alu = 1'b1;
                ctl_d.rd     = (op == 6'h13) ? LINK_REG : 5'd0;
                wr           = (op == 6'h13);
            end
            6'h02, 6'h03: begin
                ctl_d.pc_cmd = 2'd3;
                ctl_d.rs1    = '0;
                ctl_d.iv     = sext26;
                ctl_d.rd     = (op == 6'h03) ? LINK_REG : 5'd0;
                wr           = (op == 6'h03);
            end
            default: ok = 1'b0;
        endcase
        ctl_d.rfwe = wr && (ctl_d.rd != 5'd0);
        if (!ok) begin
            ctl_d         = '0;
            ctl_d.illegal = 1'b1;
        end
    end

    // Unused source fields decode to 0, so a nonzero load Rd never matches them.
    assign hazard   = HAZARD_EN && valid_q && ctl_q.dle && (ctl_q.rd != 5'd0) &&
                      ((ctl_d.rs1 == ctl_q.rd) || (ctl_d.rs2 == ctl_q.rd));
    assign in_ready = reset_n && !flush && !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign valid_d  = accept || (valid_q && !out_ready && !flush);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                ctl_q <= ctl_d;
                pc_q  <= in_pc;
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign d_write_enable  = ctl_q.dwe;
    assign d_load_enable   = ctl_q.dle;
    assign rf_write_enable = ctl_q.rfwe;
    assign Iv_alu          = ctl_q.iv_alu;
    assign Pc_alu          = ctl_q.pc_alu;
    assign Pc_cmd          = ctl_q.pc_cmd;
    assign I               = ctl_q.alu;
    assign Rs1             = ctl_q.rs1;
    assign Rs2             = ctl_q.rs2;
    assign Rd              = ctl_q.rd;
    assign Iv              = ctl_q.iv;
    assign illegal         = ctl_q.illegal;
endmodule

// File: tb/tb_dlx_decode_stage.sv
// tb_dlx_decode_stage: scoreboard bench for the DLX decode stage; directed plan cases
// followed by randomized traffic against a rule-level decode model.
module tb_dlx_decode_stage;
    typedef struct packed {
        logic        dwe;
        logic        dle;
        logic        rfwe;
        logic        iv_alu;
        logic        pc_alu;
        logic [1:0]  pc_cmd;
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] iv;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    logic        clk, reset_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, d_write_enable, d_load_enable, rf_write_enable;
    logic        Iv_alu, Pc_alu, illegal;
    logic [1:0]  Pc_cmd;
    logic [3:0]  I;
    logic [4:0]  Rs1, Rs2, Rd;
    logic [31:0] out_pc, Iv;
    logic        nh_in_ready, nh_out_valid, nh_dwe, nh_dle, nh_rfwe, nh_iv_alu, nh_pc_alu, nh_illegal;
    logic [1:0]  nh_pc_cmd;
    logic [3:0]  nh_i;
    logic [4:0]  nh_rs1, nh_rs2, nh_rd;
    logic [31:0] nh_out_pc, nh_iv;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [5:0] rfn [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06, 6'h07, 6'h2A};
    logic [5:0] ops [17] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
                             6'h23, 6'h2B, 6'h04, 6'h05, 6'h12, 6'h13, 6'h02, 6'h03};

    dlx_decode_stage #(.XLEN(32), .HAZARD_EN(1'b1), .LINK_REG(5'd31)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .d_write_enable(d_write_enable), .d_load_enable(d_load_enable),
        .rf_write_enable(rf_write_enable), .Iv_alu(Iv_alu), .Pc_alu(Pc_alu), .Pc_cmd(Pc_cmd),
        .I(I), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Iv(Iv), .illegal(illegal)
    );

    dlx_decode_stage #(.XLEN(32), .HAZARD_EN(1'b0), .LINK_REG(5'd31)) u_nohaz (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(nh_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(nh_out_valid), .out_ready(out_ready),
        .out_pc(nh_out_pc), .d_write_enable(nh_dwe), .d_load_enable(nh_dle),
        .rf_write_enable(nh_rfwe), .Iv_alu(nh_iv_alu), .Pc_alu(nh_pc_alu), .Pc_cmd(nh_pc_cmd),
        .I(nh_i), .Rs1(nh_rs1), .Rs2(nh_rs2), .Rd(nh_rd), .Iv(nh_iv), .illegal(nh_illegal)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [127:0] g, input logic [127:0] e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, g, e);
        end
    endfunction

    // Decode from the instruction-set rules: what the op writes, reads and jumps to.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t       e;
        logic [5:0] op;
        logic       r, link, writes;
        int         alu;
        e   = '0;
        e.pc = pc;
        op  = ins[31:26];
        r   = (op == 6'h00);
        alu = -1;
        if (r) begin
            for (int i = 0; i < 9; i++) if (rfn[i] == ins[5:0]) alu = i;
        end else begin
            case (op)
                6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h12, 6'h13, 6'h02, 6'h03: alu = 0;
                6'h0C: alu = 2;
                6'h0D: alu = 3;
                6'h0E: alu = 4;
                6'h0F: alu = 9;
                default: alu = -1;
            endcase
        end
        if (alu < 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.alu    = 4'(alu);
        link     = (op == 6'h03) || (op == 6'h13);
        writes   = r || link || (op inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23});
        e.rd     = link ? 5'd31 : r ? ins[15:11] : writes ? ins[20:16] : 5'd0;
        e.rfwe   = writes && (e.rd != 5'd0);
        e.rs1    = (op inside {6'h02, 6'h03, 6'h0F}) ? 5'd0 : ins[25:21];
        e.rs2    = (r || op == 6'h2B) ? ins[20:16] : 5'd0;
        e.dle    = (op == 6'h23);
        e.dwe    = (op == 6'h2B);
        e.pc_cmd = (op inside {6'h02, 6'h03, 6'h12, 6'h13}) ? 2'd3 :
                   (op == 6'h04) ? 2'd1 : (op == 6'h05) ? 2'd2 : 2'd0;
        e.pc_alu = (op == 6'h12) || (op == 6'h13);
        e.iv_alu = !r;
        if (r) e.iv = 32'h0;
        else if (op == 6'h02 || op == 6'h03) e.iv = {{6{ins[25]}}, ins[25:0]};
        else if (op == 6'h0F) e.iv = {ins[15:0], 16'h0000};
        else if (op inside {6'h0C, 6'h0D, 6'h0E}) e.iv = {16'h0000, ins[15:0]};
        else e.iv = {{16{ins[15]}}, ins[15:0]};
        return e;
    endfunction

    function automatic exp_t got();
        exp_t g;
        g = '{dwe: d_write_enable, dle: d_load_enable, rfwe: rf_write_enable, iv_alu: Iv_alu,
              pc_alu: Pc_alu, pc_cmd: Pc_cmd, alu: I, rs1: Rs1, rs2: Rs2, rd: Rd, iv: Iv,
              illegal: illegal, pc: out_pc};
        return g;
    endfunction

    // Monitor: mid-cycle, compare presented output to the queue head, then retire/enqueue.
    always @(negedge clk) begin
        exp_t m;
        logic ev, hz, er;
        if (!reset_n) begin
            sb.delete();
            chk("reset_valid", {126'd0, out_valid, in_ready}, 128'd0);
            chk("reset_outs", 128'(got()), 128'd0);
        end else begin
            m  = model(in_instr, in_pc);
            ev = (sb.size() > 0);
            hz = ev && sb[0].dle && (sb[0].rd != 5'd0) && (m.rs1 == sb[0].rd || m.rs2 == sb[0].rd);
            er = !flush && !hz && (!ev || out_ready);
            chk("out_valid", 128'(out_valid), 128'(ev));
            chk("in_ready", 128'(in_ready), 128'(er));
            if (ev && out_valid) chk("decoded", 128'(got()), 128'(sb[0]));
            if (ev && (out_ready || flush)) void'(sb.pop_front());
            if (in_valid && er) sb.push_back(m);
        end
    end

    task automatic set(input logic v, input logic [31:0] ins, input logic r, input logic f);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = $urandom;
        out_ready = r;
        flush     = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] ins;
        int          k;
        ins        = $urandom;
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        ins[15:11] = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 19);
        if (k < 17) ins[31:26] = ops[k];
        if (ins[31:26] == 6'h00 && $urandom_range(0, 9) != 0) ins[5:0] = rfn[$urandom_range(0, 8)];
        return ins;
    endfunction

    initial begin
        clk = 1'b0;
        reset_n = 1'b1;
        set(1'b0, 32'h0, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        // ADDI r3,r1,-4
        set(1'b1, 32'h2023FFFC, 1'b1, 1'b0);
        step();
        chk("addi", {out_valid, Rs1, Rd, Iv, Iv_alu, I, rf_write_enable, Pc_cmd},
            {1'b1, 5'd1, 5'd3, 32'hFFFFFFFC, 1'b1, 4'd0, 1'b1, 2'd0});
        // LW r2,0(r1) then dependent ADD r4,r2,r5
        set(1'b1, 32'h8C220000, 1'b1, 1'b0);
        step();
        chk("lw", {out_valid, d_load_enable, Rd}, {1'b1, 1'b1, 5'd2});
        set(1'b1, 32'h00452020, 1'b1, 1'b0);
        #2 chk("hazard_stall", {in_ready, nh_in_ready}, {1'b0, 1'b1});
        step();
        chk("bubble", {out_valid, nh_out_valid, nh_rd}, {1'b0, 1'b1, 5'd4});
        set(1'b1, 32'h00452020, 1'b1, 1'b0);
        #2 chk("hazard_clear", 128'(in_ready), 128'd1);
        step();
        chk("add", {out_valid, Rs1, Rs2, Rd, I, Iv_alu}, {1'b1, 5'd2, 5'd5, 5'd4, 4'd0, 1'b0});
        // JAL 0x100, JR r7
        set(1'b1, 32'h0C000100, 1'b1, 1'b0);
        step();
        chk("jal", {Pc_cmd, Pc_alu, Rd, Iv, rf_write_enable}, {2'd3, 1'b0, 5'd31, 32'h100, 1'b1});
        set(1'b1, 32'h48E00000, 1'b1, 1'b0);
        step();
        chk("jr", {Pc_cmd, Pc_alu, Rs1, rf_write_enable}, {2'd3, 1'b1, 5'd7, 1'b0});
        // illegal opcode and illegal funct
        set(1'b1, 32'hFC000000, 1'b1, 1'b0);
        step();
        chk("ill_op", {out_valid, illegal, d_write_enable, d_load_enable, rf_write_enable, Pc_cmd},
            {1'b1, 1'b1, 3'b000, 2'd0});
        set(1'b1, 32'h0000003F, 1'b1, 1'b0);
        step();
        chk("ill_fn", {out_valid, illegal, d_write_enable, d_load_enable, rf_write_enable, Pc_cmd},
            {1'b1, 1'b1, 3'b000, 2'd0});
        // SW r5,8(r6) held under backpressure
        set(1'b1, 32'hACC50008, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            set(1'b1, 32'h2023FFFC, 1'b0, 1'b0);
            #2 chk("sw_hold", {in_ready, out_valid, d_write_enable, Rs1, Rs2, Iv},
                   {1'b0, 1'b1, 1'b1, 5'd6, 5'd5, 32'd8});
            step();
        end
        set(1'b0, 32'h0, 1'b1, 1'b0);
        #2 chk("sw_release", {out_valid, d_write_enable, Rs1, Rs2, Iv}, {1'b1, 1'b1, 5'd6, 5'd5, 32'd8});
        step();
        chk("sw_once", 128'(out_valid), 128'd0);
        // flush during backpressure
        set(1'b1, 32'h2023FFFC, 1'b1, 1'b0);
        step();
        set(1'b1, 32'h34220005, 1'b0, 1'b1);
        #2 chk("flush_ready", 128'(in_ready), 128'd0);
        step();
        chk("flush_clear", 128'(out_valid), 128'd0);
        // asynchronous reset while stalled
        set(1'b1, 32'h8C220000, 1'b1, 1'b0);
        step();
        set(1'b1, 32'h00452020, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", {127'(got()), out_valid, in_ready}, 128'd0);
        step();
        reset_n = 1'b1;
        set(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("post_reset", 128'(out_valid), 128'd0);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            set($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0);
            step();
        end
        set(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) step();
        chk("drain", 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dlx_decode_stage.md
Name: dlx_decode_stage

Overview:
- Parametrised, handshaked DLX instruction decode stage between fetch and execute.
- Accepts one instruction per cycle under valid/ready and decodes R/I/J formats into ALU, memory, PC and register-file controls.
- Holds the decoded result in an output register.
- Adds backpressure, flush, load-use interlock and illegal-opcode detection.

Parameters:
- XLEN, 32, datapath and immediate width; must be 32 or more.
- HAZARD_EN, 1, 1 enables the load-use interlock; 0 disables it.
- LINK_REG, 31, destination register written by JAL/JALR.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  drop the held instruction and refuse input this cycle
- in_valid  in  1  fetch holds an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute accepts the held instruction
- out_pc  out  XLEN  registered in_pc
- d_write_enable  out  1  store
- d_load_enable  out  1  load
- rf_write_enable  out  1  register-file write; 0 when Rd==0
- Iv_alu  out  1  ALU operand B is Iv (1) or Rs2 (0)
- Pc_alu  out  1  jump target from Rs1 (JR/JALR)
- Pc_cmd  out  2  0 seq, 1 branch if Rs1==0, 2 branch if Rs1!=0, 3 jump
- I  out  4  ALU op
- Rs1, Rs2, Rd  out  5 each  register indices
- Iv  out  XLEN  extended immediate
- illegal  out  1  unknown opcode or funct

Behaviour:
- Reset: asynchronous on reset_n low. Every output register, out_valid and illegal go to 0. in_ready is combinational and reads 0 while reset_n is low.
- Fields: opcode [31:26]. Rs1 [25:21] for all formats.
  - R-type (opcode 0x00): Rs2 [20:16], Rd [15:11], funct [5:0].
  - I-type: Rd [20:16] (Rs2 for SW and BEQZ/BNEZ unused), imm16 [15:0].
  - J-type: off26 [25:0], sign-extended to XLEN.
- ALU op I, R-type funct:
  - 0x20 ADD=0, 0x22 SUB=1, 0x24 AND=2, 0x25 OR=3, 0x26 XOR=4.
  - 0x04 SLL=5, 0x06 SRL=6, 0x07 SRA=7, 0x2A SLT=8.
- I-type opcodes:
  - 0x08 ADDI: I=0, sign-extended imm.
  - 0x0C ANDI / 0x0D ORI / 0x0E XORI: I=2/3/4, zero-extended imm.
  - 0x0F LHI: I=9, Iv=imm16<<16.
  - 0x23 LW: I=0, sign-extended imm, d_load_enable=1.
  - 0x2B SW: I=0, sign-extended imm, Rs2=[20:16], d_write_enable=1, rf_write_enable=0.
  - 0x04 BEQZ: Pc_cmd=1. 0x05 BNEZ: Pc_cmd=2. Both sign-extended imm, rf_write_enable=0.
  - 0x12 JR / 0x13 JALR: Pc_cmd=3, Pc_alu=1.
- J-type opcodes: 0x02 J, 0x03 JAL, both Pc_cmd=3.
- JAL/JALR: Rd=LINK_REG, rf_write_enable=1.
- Source usage: Rs1 is used by all formats except J/JAL/LHI. Rs2 is used by R-type and SW. Unused Rs fields are output as 0.
- Illegal opcode/funct: output as a NOP with illegal=1.
  - NOP means all enables 0, Pc_cmd=0, I=0.
  - out_valid is still asserted; execute traps on illegal.
- Latency: an instruction accepted in cycle N appears on the outputs with out_valid=1 in cycle N+1.
- Handshake:
  - in_ready = reset_n & !flush & !hazard & (!out_valid | out_ready).
  - The output register loads on in_valid & in_ready.
  - While out_valid & !out_ready, all outputs hold stable.
  - If out_ready=1 with no new accept, out_valid goes to 0 next cycle.
- Hazard (only when HAZARD_EN=1):
  - Condition: out_valid & d_load_enable & Rd!=0, and in_instr uses that register as Rs1 or Rs2.
  - Effect: in_ready=0. When the load leaves, out_valid goes to 0 for exactly one cycle (one bubble), then the consumer is accepted.
- Flush:
  - out_valid goes to 0 next cycle and nothing is accepted that cycle.
  - flush with out_valid & out_ready: the transfer completes and the register is still cleared.
- Reset mid-stall: the held instruction is discarded and no partial output remains.

Test Plan:
- ADDI r3,r1,-4 (0x2023FFFC), out_ready=1 -> next cycle: out_valid=1, Rs1=1, Rd=3, Iv=0xFFFFFFFC, Iv_alu=1, I=0, rf_write_enable=1, Pc_cmd=0.
- LW r2,0(r1) (0x8C220000) then ADD r4,r2,r5 (0x00452020) back-to-back ->
  - LW output with d_load_enable=1; in_ready=0 for one cycle; one out_valid=0 bubble.
  - ADD then output with Rs1=2, Rs2=5, Rd=4, I=0, Iv_alu=0.
  - With HAZARD_EN=0, no bubble.
- JAL off=0x100 (0x0C000100) -> Pc_cmd=3, Pc_alu=0, Rd=31, Iv=0x00000100, rf_write_enable=1. JR r7 (0x48E00000) -> Pc_cmd=3, Pc_alu=1, Rs1=7, rf_write_enable=0.
- Opcode 0x3F (0xFC000000) and R-type funct 0x3F (0x0000003F) -> out_valid=1, illegal=1, all enables 0, Pc_cmd=0.
- out_ready low for 3 cycles with a held SW r5,8(r6) (0xACC50008) -> all outputs stable, in_ready=0. After release: d_write_enable=1, Rs1=6, Rs2=5, Iv=8 transfers once.
- Flush during backpressure -> out_valid=0 next cycle, pending input not accepted. reset_n low mid-stream -> all outputs 0 immediately (asynchronous).
